// File: rtl/mcb_arb_pkg.sv
// Shared encodings for the MCB command arbiter: FSM states, MCB instruction
// codes, burst length and byte-address width.
package mcb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

    localparam logic [2:0] MCB_INSTR_WR    = 3'b000;
    localparam logic [2:0] MCB_INSTR_RD    = 3'b001;
    localparam logic [5:0] MCB_BL_256B     = 6'd63;
    localparam int         MCB_BYTE_ADDR_W = 30;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after last+1,
// wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [IW-1:0]   win,
    output logic            valid
);

    always_comb begin
        win   = '0;
        valid = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(last) + k) % NREQ;
            if (!valid && req[idx]) begin
                valid = 1'b1;
                win   = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/mcb_cmd_arb.sv
// Round-robin arbiter sharing one MCB command port among NREQ burst requesters.
// Define MCB_ARB_STATS_EN to add saturating per-requester grant counters (grant_cnt).
module mcb_cmd_arb
    import mcb_arb_pkg::*;
#(
    parameter int NREQ           = 4,
    parameter int APP_ADDR_WIDTH = 18,
    parameter int GAP_CYCLES     = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         calib_done,
    input  logic [NREQ-1:0]              req,
    input  logic [NREQ-1:0]              req_rd,
    input  logic [NREQ*APP_ADDR_WIDTH-1:0] req_addr,
    output logic [NREQ-1:0]              gnt,
    input  logic                         cmd_full,
    output logic                         cmd_en,
    output logic [2:0]                   cmd_instr,
    output logic [5:0]                   cmd_bl,
    output logic [MCB_BYTE_ADDR_W-1:0]   cmd_byte_addr,
    output logic                         busy
`ifdef MCB_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]           grant_cnt
`endif
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e      state, state_nxt;
    logic [IW-1:0]   last, pick_win;
    logic            pick_vld;
    logic [NREQ-1:0] mask, req_eff, pick_oh;
    logic [2:0]      gap_cnt;
    logic            sel;

    // Masking the just-granted requester covers the cycle it needs to drop req.
    assign req_eff = req & ~mask;
    assign pick_oh = NREQ'(1) << pick_win;
    assign sel     = (state == IDLE) && calib_done && !cmd_full && pick_vld;
    assign cmd_bl  = MCB_BL_256B;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req   (req_eff),
        .last  (last),
        .win   (pick_win),
        .valid (pick_vld)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sel) state_nxt = ISSUE;
            ISSUE:   state_nxt = GAP;
            GAP:     if (gap_cnt == 3'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last          <= IW'(NREQ - 1);
            mask          <= '0;
            gap_cnt       <= '0;
            cmd_en        <= 1'b0;
            gnt           <= '0;
            cmd_instr     <= MCB_INSTR_WR;
            cmd_byte_addr <= '0;
            busy          <= 1'b0;
        end else begin
            cmd_en <= sel;
            gnt    <= sel ? pick_oh : '0;
            busy   <= (state_nxt != IDLE);
            if (sel) begin
                last          <= pick_win;
                mask          <= pick_oh;
                cmd_instr     <= req_rd[pick_win] ? MCB_INSTR_RD : MCB_INSTR_WR;
                cmd_byte_addr <= MCB_BYTE_ADDR_W'({req_addr[pick_win*APP_ADDR_WIDTH +: APP_ADDR_WIDTH], 8'd0});
            end else if (state_nxt == IDLE) begin
                mask <= '0;
            end
            if (state == ISSUE)
                gap_cnt <= 3'(GAP_CYCLES - 1);
            else if (state == GAP && gap_cnt != 3'd0)
                gap_cnt <= gap_cnt - 3'd1;
        end
    end

`ifdef MCB_ARB_STATS_EN
    logic [NREQ-1:0][15:0] cnt;

    // gnt is high exactly in the ISSUE cycle, so it doubles as the increment strobe.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++)
                if (gnt[i] && cnt[i] != 16'hFFFF) cnt[i] <= cnt[i] + 16'd1;
        end
    end

    assign grant_cnt = cnt;
`endif

endmodule

// File: tb/tb_mcb_cmd_arb.sv
// Directed bench for mcb_cmd_arb: reset, single grant, fairness, backpressure,
// calibration gate, withdrawal, mid-ISSUE reset and (optionally) grant counters.
module tb_mcb_cmd_arb;

    localparam int NREQ = 4;
    localparam int AW   = 18;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              calib_done;
    logic [NREQ-1:0]   req, req_rd, gnt;
    logic [NREQ*AW-1:0] req_addr;
    logic              cmd_full, cmd_en, busy;
    logic [2:0]        cmd_instr;
    logic [5:0]        cmd_bl;
    logic [29:0]       cmd_byte_addr;
`ifdef MCB_ARB_STATS_EN
    logic [NREQ*16-1:0] grant_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    mcb_cmd_arb #(.NREQ(NREQ), .APP_ADDR_WIDTH(AW), .GAP_CYCLES(2)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .calib_done    (calib_done),
        .req           (req),
        .req_rd        (req_rd),
        .req_addr      (req_addr),
        .gnt           (gnt),
        .cmd_full      (cmd_full),
        .cmd_en        (cmd_en),
        .cmd_instr     (cmd_instr),
        .cmd_bl        (cmd_bl),
        .cmd_byte_addr (cmd_byte_addr),
        .busy          (busy)
`ifdef MCB_ARB_STATS_EN
        ,
        .grant_cnt     (grant_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        repeat (n) tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_idle();
        int w = 0;
        while (busy && w < 20) begin
            tick();
            w++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic wait_cmd(input string tag);
        int w = 0;
        do begin
            tick();
            w++;
        end while (!cmd_en && w < 12);
        chk(tag, cmd_en, 1);
    endtask

    initial begin
        logic seen;
        int   prev;
        logic [3:0] fair_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        reset_n    = 1'b0;
        calib_done = 1'b1;
        cmd_full   = 1'b0;
        req        = '0;
        req_rd     = '0;
        req_addr   = '0;
        do_reset(3);

        chk("rst_cmd_en", cmd_en, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_instr", cmd_instr, 0);
        chk("rst_addr", cmd_byte_addr, 0);
        chk("cmd_bl", cmd_bl, 63);

        // single read request from requester 2
        req                = 4'b0100;
        req_rd             = 4'b0100;
        req_addr[2*AW +: AW] = 18'h00ABC;
        tick();
        chk("single_cmd_en", cmd_en, 1);
        chk("single_gnt", gnt, 4'b0100);
        chk("single_instr", cmd_instr, 3'b001);
        chk("single_addr", cmd_byte_addr, 30'h000ABC00);
        chk("single_busy", busy, 1);
        req = '0;
        tick();
        chk("single_pulse_en", cmd_en, 0);
        chk("single_pulse_gnt", gnt, 0);
        chk("addr_hold", cmd_byte_addr, 30'h000ABC00);
        wait_idle();

        // fairness: all four requesting, 4-cycle spacing
        do_reset(2);
        req    = 4'b1111;
        req_rd = 4'b1010;
        prev   = 0;
        for (int g = 0; g < 5; g++) begin
            wait_cmd("fair_timeout");
            chk($sformatf("fair_gnt%0d", g), gnt, fair_exp[g]);
            chk($sformatf("fair_instr%0d", g), cmd_instr, (fair_exp[g] & 4'b1010) != 0);
            if (g > 0) chk($sformatf("fair_spacing%0d", g), cyc - prev, 4);
            prev = cyc;
        end
        req = '0;
        wait_idle();

        // backpressure
        do_reset(2);
        cmd_full = 1'b1;
        req      = 4'b0011;
        seen     = 1'b0;
        repeat (10) begin
            tick();
            seen |= cmd_en;
        end
        chk("full_no_cmd", seen, 0);
        cmd_full = 1'b0;
        tick();
        chk("full_release_en", cmd_en, 1);
        chk("full_release_gnt", gnt, 4'b0001);
        req = '0;
        wait_idle();

        // calibration gate
        calib_done = 1'b0;
        req        = 4'b0001;
        seen       = 1'b0;
        repeat (20) begin
            tick();
            seen |= cmd_en;
        end
        chk("calib_no_cmd", seen, 0);
        calib_done = 1'b1;
        tick();
        chk("calib_gnt", gnt, 4'b0001);
        req = '0;
        wait_idle();

        // withdrawal: req[1] pulsed during GAP only
        req = 4'b0100;
        tick();
        chk("wd_gnt", gnt, 4'b0100);
        req = '0;
        tick();
        req = 4'b0010;
        tick();
        req  = '0;
        seen = 1'b0;
        repeat (4) begin
            tick();
            seen |= cmd_en;
        end
        chk("wd_no_cmd", seen, 0);

        // reset in the ISSUE cycle
        req = 4'b1000;
        tick();
        chk("mid_gnt", gnt, 4'b1000);
        reset_n = 1'b0;
        tick();
        chk("mid_rst_en", cmd_en, 0);
        chk("mid_rst_gnt", gnt, 0);
        reset_n = 1'b1;
        req     = 4'b1001;
        tick();
        chk("post_rst_gnt", gnt, 4'b0001);
        req = '0;
        wait_idle();

`ifdef MCB_ARB_STATS_EN
        do_reset(2);
        req = 4'b1000;
        for (int g = 0; g < 5; g++) begin
            wait_cmd("stats_timeout");
            chk("stats_gnt", gnt, 4'b1000);
        end
        req = '0;
        wait_idle();
        chk("stats_cnt3", grant_cnt[63:48], 16'd5);
        chk("stats_cnt_other", grant_cnt[47:0], 48'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
